// File: rtl/hs_pkg.sv
// hs_pkg: shared state type and default parameters for the req/ack handshake sender.
package hs_pkg;
  typedef enum logic [1:0] {IDLE, REQ, REL} hs_state_t;
  localparam int DATA_WIDTH_DEF     = 32;
  localparam int SYNC_STAGES_DEF    = 2;
  localparam int TIMEOUT_CYCLES_DEF = 1024;
endpackage

// File: rtl/hs_sender_sync_chain.sv
// sync_chain: STAGES-deep flop chain that brings an asynchronous level into the clk domain.
// Ports: clk (local clock), areset (async active-high, clears chain to 0),
//        i_d (asynchronous level in), o_q (synchronized level out).
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic areset,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;
  always_ff @(posedge clk or posedge areset)
    if (areset) r_sync <= '0;
    else        r_sync <= {r_sync[STAGES-2:0], i_d};
  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/hs_sender.sv
// hs_sender: source side of a four-phase req/ack handshake into a foreign clock domain.
// Ports: clk/areset (local clock, async active-high reset); i_data/i_valid/o_ready (local
//        accept of a word); o_data/o_req (word and request level to the remote side);
//        i_ack (asynchronous remote acknowledge); o_busy (transfer in flight);
//        o_done/o_timeout (one-cycle completion or timeout pulses). All outputs are flops.
module hs_sender
  import hs_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_req,
  input  logic                  i_ack,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_timeout
);
  localparam int          CW      = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TMAX    = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TMAX);
  localparam bit          TMO_EN  = TIMEOUT_CYCLES != 0;

  hs_state_t             r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic r_req, r_ready, r_busy, r_done, r_timeout, r_tmo_flag;
  logic w_ack_s, w_tmo_hit, w_done, w_req, w_ready, w_busy;

  sync_chain #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk    (clk),
    .areset (areset),
    .i_d    (i_ack),
    .o_q    (w_ack_s)
  );

  // An ack seen in the same cycle as the last count wins over the timeout.
  always_comb w_tmo_hit = TMO_EN && r_state == REQ && !w_ack_s && r_cnt == CNT_MAX;

  always_ff @(posedge clk or posedge areset)
    if (areset) r_state <= IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_valid ? REQ : IDLE;
      REQ:     w_next = (w_ack_s || w_tmo_hit) ? REL : REQ;
      REL:     w_next = w_ack_s ? REL : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered copies line up with it.
  always_comb begin
    w_req   = w_next == REQ;
    w_ready = w_next == IDLE;
    w_busy  = w_next != IDLE;
    w_done  = r_state == REL && !w_ack_s && !r_tmo_flag;
  end

  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      r_data     <= '0;
      r_cnt      <= '0;
      r_tmo_flag <= 1'b0;
      r_req      <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (r_state == IDLE && i_valid) r_data <= i_data;
      r_cnt      <= (r_state == REQ && !w_ack_s) ? r_cnt + CW'(1) : '0;
      r_tmo_flag <= r_state != IDLE && (r_tmo_flag || w_tmo_hit);
      r_req      <= w_req;
      r_ready    <= w_ready;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_timeout  <= w_tmo_hit;
    end

  assign o_ready   = r_ready;
  assign o_data    = r_data;
  assign o_req     = r_req;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_timeout = r_timeout;
endmodule

// File: tb/tb_hs_sender.sv
// tb_hs_sender: directed and randomized checks of hs_sender against a transfer-level model.
module tb_hs_sender;
  localparam int SYNC = 2;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        areset;
  logic [31:0] i_data;
  logic        i_valid, i_ack;
  logic        o_ready, o_req, o_busy, o_done, o_timeout;
  logic [31:0] o_data;

  int checks = 0, errors = 0;
  int n_done = 0, n_to = 0;
  bit started = 0, resp_on = 0, rnd = 0;
  int ack_dly = 3, rel_dly = 3, rc = 0;

  hs_sender #(.DATA_WIDTH(32), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .areset    (areset),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_req     (o_req),
    .i_ack     (i_ack),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_timeout (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transfer-level model: phase 0 idle, 1 requesting, 2 releasing; age counts edges since accept.
  int          m_phase, m_age;
  bit          m_tof, m_done, m_to;
  logic [31:0] m_data;
  bit          ackq[$];

  always @(posedge clk or posedge areset) begin : mdl
    bit a;
    if (areset) begin
      m_phase = 0; m_age = 0; m_tof = 0; m_done = 0; m_to = 0; m_data = '0;
      ackq.delete();
      for (int i = 0; i < SYNC; i++) ackq.push_back(1'b0);
    end else begin
      a = ackq.pop_front();
      ackq.push_back(i_ack);
      m_done = 0;
      m_to   = 0;
      if (m_phase == 0) begin
        if (i_valid) begin m_phase = 1; m_age = 0; m_tof = 0; m_data = i_data; end
      end else if (m_phase == 1) begin
        m_age++;
        if (a) m_phase = 2;
        else if (TMO != 0 && m_age == TMO) begin m_to = 1; m_tof = 1; m_phase = 2; end
      end else if (!a) begin
        m_phase = 0;
        m_done  = !m_tof;
      end
    end
  end

  always @(negedge clk)
    if (started && !areset) begin
      chk("req",     o_req,     m_phase == 1);
      chk("ready",   o_ready,   m_phase == 0);
      chk("busy",    o_busy,    m_phase != 0);
      chk("done",    o_done,    m_done);
      chk("timeout", o_timeout, m_to);
      chk("data",    o_data,    m_data);
    end

  always @(negedge clk)
    if (!areset) begin
      if (o_done)    n_done++;
      if (o_timeout) n_to++;
    end

  // Remote side: raise ack ack_dly cycles after seeing req, drop it rel_dly cycles after req falls.
  always @(negedge clk)
    if (resp_on) begin
      if (o_req && !i_ack) begin
        rc++;
        if (rc >= ack_dly) begin
          i_ack = 1'b1; rc = 0;
          if (rnd) rel_dly = $urandom_range(6, 1);
        end
      end else if (!o_req && i_ack) begin
        rc++;
        if (rc >= rel_dly) begin
          i_ack = 1'b0; rc = 0;
          if (rnd) ack_dly = $urandom_range(20, 1);
        end
      end else rc = 0;
    end

  task automatic xfer(input logic [31:0] d, output int reqc, output int lat);
    int k = 0;
    while (!o_ready && k < 200) begin @(negedge clk); k++; end
    i_valid = 1'b1; i_data = d;
    @(negedge clk);
    i_valid = 1'b0;
    reqc = 0; lat = 0;
    while (!o_ready && lat < 300) begin
      if (o_req) reqc++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int d0, t0, k, reqc, lat;
    areset = 1'b1; i_valid = 1'b0; i_data = '0; i_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", o_ready, 1); chk("rst_req", o_req, 0); chk("rst_data", o_data, 0);
    chk("rst_busy", o_busy, 0); chk("rst_done", o_done, 0); chk("rst_to", o_timeout, 0);
    areset = 1'b0; started = 1;
    @(negedge clk);

    // Normal transfer, ack 3 cycles after req, release 3 after req fall; retry ignored in REQ.
    resp_on = 1; ack_dly = 3; rel_dly = 3;
    d0 = n_done; t0 = n_to;
    i_valid = 1'b1; i_data = 32'hDEADBEEF;
    @(negedge clk);
    i_valid = 1'b0;
    k = 0;
    while (!o_done && k < 100) begin
      i_valid = (k == 1);
      if (k == 1) i_data = 32'h12345678;
      if (o_busy) chk("hold_data", o_data, 32'hDEADBEEF);
      @(negedge clk);
      k++;
    end
    i_valid = 1'b0;
    chk("lat_done", k, 10);
    chk("ready_at_done", o_ready, 1);
    repeat (3) @(negedge clk);
    chk("data_kept", o_data, 32'hDEADBEEF);
    chk("n_done_1", n_done - d0, 1);
    chk("n_to_1", n_to - t0, 0);

    // Remote never acks: timeout after 16 cycles of req.
    ack_dly = 1000; d0 = n_done; t0 = n_to;
    xfer(32'hCAFE0001, reqc, lat);
    chk("tmo_reqc", reqc, 16);
    chk("tmo_lat", lat, 17);
    repeat (2) @(negedge clk);
    chk("tmo_n_to", n_to - t0, 1);
    chk("tmo_n_done", n_done - d0, 0);

    // Stale ack in IDLE is ignored; next transfer waits in REL for ack low and still completes.
    resp_on = 0; i_ack = 1'b1; d0 = n_done;
    repeat (4) @(negedge clk);
    chk("stale_ready", o_ready, 1);
    chk("stale_req", o_req, 0);
    i_valid = 1'b1; i_data = 32'hA5A5A5A5;
    @(negedge clk);
    i_valid = 1'b0;
    chk("stale_req_up", o_req, 1);
    @(negedge clk);
    chk("stale_req_dn", o_req, 0);
    repeat (5) begin chk("stale_wait", o_busy, 1); @(negedge clk); end
    i_ack = 1'b0;
    k = 0;
    while (!o_done && k < 50) begin @(negedge clk); k++; end
    chk("stale_lat", k, 3);
    repeat (2) @(negedge clk);
    chk("stale_n_done", n_done - d0, 1);

    // Asynchronous reset in REQ drops req immediately with no pulses.
    resp_on = 1; ack_dly = 1000; d0 = n_done; t0 = n_to;
    i_valid = 1'b1; i_data = 32'h0BADF00D;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", o_req, 1);
    #2 areset = 1'b1;
    #1;
    chk("arst_req", o_req, 0); chk("arst_ready", o_ready, 1); chk("arst_busy", o_busy, 0);
    chk("arst_done", o_done, 0); chk("arst_to", o_timeout, 0); chk("arst_data", o_data, 0);
    @(negedge clk);
    areset = 1'b0;
    repeat (4) @(negedge clk);
    chk("arst_n_done", n_done - d0, 0);
    chk("arst_n_to", n_to - t0, 0);

    // ack_s rises in the last counted cycle: ack wins.
    ack_dly = 14; rel_dly = 2; d0 = n_done; t0 = n_to;
    xfer(32'h11112222, reqc, lat);
    chk("coin_reqc", reqc, 16);
    chk("coin_lat", lat, 20);
    repeat (2) @(negedge clk);
    chk("coin_n_done", n_done - d0, 1);
    chk("coin_n_to", n_to - t0, 0);

    // One cycle later the timeout fires first and suppresses done.
    ack_dly = 15; d0 = n_done; t0 = n_to;
    xfer(32'h33334444, reqc, lat);
    chk("late_reqc", reqc, 16);
    chk("late_lat", lat, 20);
    repeat (2) @(negedge clk);
    chk("late_n_done", n_done - d0, 0);
    chk("late_n_to", n_to - t0, 1);

    // Randomized traffic and remote delays, checked cycle by cycle against the model.
    rnd = 1; ack_dly = $urandom_range(20, 1); rel_dly = $urandom_range(6, 1);
    repeat (3000) begin
      @(negedge clk);
      i_valid = ($urandom_range(3, 0) == 0);
      i_data  = $urandom;
    end
    i_valid = 1'b0;
    repeat (60) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
